// File: rtl/pim_pkg.sv
// Shared types and helpers for the PIM partial-sum path.
package pim_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSweep,
    StFlush,
    StDrain
  } pim_state_e;

  // Number of crossbar columns addressed by a DEPTH-bit column address.
  function automatic int unsigned num_cols(int unsigned depth);
    return 32'd1 << depth;
  endfunction

  // Unsigned add clamped to 2^width-1; shared with the requant stage.
  function automatic logic [31:0] sat_add(logic [31:0] a, logic [31:0] b, int unsigned width);
    logic [32:0] sum;
    logic [32:0] max;
    sum = {1'b0, a} + {1'b0, b};
    max = (33'd1 << width) - 33'd1;
    return (sum > max) ? max[31:0] : sum[31:0];
  endfunction

endpackage

// File: rtl/pim_psum_collector_if.sv
// Handshake bundle between the collector, the tile source, the PIM macro and the drain sink.
interface pim_psum_collector_if #(
  parameter int unsigned DEPTH = 5,
  parameter int unsigned ADC_P = 6,
  parameter int unsigned ACC_W = 12
);
  logic             start;
  logic             busy;
  logic             in_valid;
  logic             in_ready;
  logic             pim_en;
  logic [DEPTH-1:0] pim_addr;
  logic [ADC_P-1:0] pim_out;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_data;
  logic [DEPTH-1:0] out_col;
  logic             out_last;

  modport master (
    input  start, in_valid, pim_out, out_ready,
    output busy, in_ready, pim_en, pim_addr, out_valid, out_data, out_col, out_last
  );

  modport slave (
    output start, in_valid, pim_out, out_ready,
    input  busy, in_ready, pim_en, pim_addr, out_valid, out_data, out_col, out_last
  );
endinterface

// File: rtl/pim_lat_pipe.sv
// LAT-deep shift pipe tracking {issued, col, first_tile} alongside the macro latency.
module pim_lat_pipe #(
  parameter int unsigned DEPTH = 5,
  parameter int unsigned LAT   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue_valid,
  input  logic [DEPTH-1:0] issue_col,
  input  logic             issue_first,
  output logic             cap_valid,
  output logic [DEPTH-1:0] cap_col,
  output logic             cap_first,
  output logic             settled
);
  typedef struct packed {
    logic             valid;
    logic [DEPTH-1:0] col;
    logic             first;
  } entry_t;

  entry_t stage_q [LAT];

  // Shift one entry per cycle; stage LAT-1 lines up with pim_out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(LAT); i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= '{valid: issue_valid, col: issue_col, first: issue_first};
      for (int i = 1; i < int'(LAT); i++) stage_q[i] <= stage_q[i-1];
    end
  end

  // Settled once nothing issued remains ahead of the output stage: the output
  // stage is captured this cycle, so the array is final from the next cycle on.
  always_comb begin
    settled = 1'b1;
    for (int i = 0; i < int'(LAT) - 1; i++) begin
      if (stage_q[i].valid) settled = 1'b0;
    end
  end

  assign cap_valid = stage_q[LAT-1].valid;
  assign cap_col   = stage_q[LAT-1].col;
  assign cap_first = stage_q[LAT-1].first;
endmodule

// File: rtl/pim_psum_collector.sv
// Sweeps macro columns per tile, accumulates per-column sums over tiles, drains them as a stream.
module pim_psum_collector
  import pim_pkg::*;
#(
  parameter int unsigned DEPTH     = 5,
  parameter int unsigned ADC_P     = 6,
  parameter int unsigned ACC_W     = 12,
  parameter int unsigned NUM_TILES = 4,
  parameter int unsigned PIM_LAT   = 1
) (
  input logic                 clk,
  input logic                 rst,
  pim_psum_collector_if.master bus
);
  localparam int unsigned     NUM_COLS = num_cols(DEPTH);
  localparam int unsigned     TILE_W   = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1;
  localparam logic [DEPTH-1:0] LastCol = DEPTH'(NUM_COLS - 1);
  localparam logic [TILE_W-1:0] LastTile = TILE_W'(NUM_TILES - 1);

  pim_state_e        state_q, state_d;
  logic [DEPTH-1:0]  col_q, col_d;
  logic [TILE_W-1:0] tile_q, tile_d;
  logic [ACC_W-1:0]  acc_q [NUM_COLS];

  logic              issue;
  logic              cap_valid;
  logic [DEPTH-1:0]  cap_col;
  logic              cap_first;
  logic              settled;

  pim_lat_pipe #(
    .DEPTH (DEPTH),
    .LAT   (PIM_LAT)
  ) u_lat_pipe (
    .clk         (clk),
    .rst         (rst),
    .issue_valid (issue),
    .issue_col   (col_q),
    .issue_first (tile_q == '0),
    .cap_valid   (cap_valid),
    .cap_col     (cap_col),
    .cap_first   (cap_first),
    .settled     (settled)
  );

  // Control state: FSM, column and tile counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      col_q   <= '0;
      tile_q  <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      tile_q  <= tile_d;
    end
  end

  // Accumulator file; first tile overwrites so stale contents never leak into a new job.
  always_ff @(posedge clk) begin
    if (cap_valid) begin
      if (cap_first) begin
        acc_q[cap_col] <= ACC_W'(bus.pim_out);
      end else begin
        acc_q[cap_col] <= ACC_W'(sat_add(32'(acc_q[cap_col]), 32'(bus.pim_out), ACC_W));
      end
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_d       = state_q;
    col_d         = col_q;
    tile_d        = tile_q;
    issue         = 1'b0;
    bus.busy      = (state_q != StIdle);
    bus.in_ready  = 1'b0;
    bus.pim_en    = 1'b0;
    bus.pim_addr  = '0;
    bus.out_valid = 1'b0;
    bus.out_data  = '0;
    bus.out_col   = '0;
    bus.out_last  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d = StSweep;
          col_d   = '0;
          tile_d  = '0;
        end
      end
      StSweep: begin
        bus.pim_addr = col_q;
        if (bus.in_valid) begin
          issue      = 1'b1;
          bus.pim_en = 1'b1;
          col_d      = col_q + DEPTH'(1);
          if (col_q == LastCol) begin
            bus.in_ready = 1'b1;
            col_d        = '0;
            if (tile_q != LastTile) tile_d = tile_q + TILE_W'(1);
            else                    state_d = StFlush;
          end
        end
      end
      StFlush: begin
        if (settled) begin
          state_d = StDrain;
          col_d   = '0;
        end
      end
      StDrain: begin
        bus.out_valid = 1'b1;
        bus.out_data  = acc_q[col_q];
        bus.out_col   = col_q;
        bus.out_last  = (col_q == LastCol);
        if (bus.out_ready) begin
          col_d = col_q + DEPTH'(1);
          if (col_q == LastCol) begin
            state_d = StIdle;
            col_d   = '0;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end
endmodule

// File: tb/tb_pim_psum_collector.sv
// Directed bench: three collectors (default, ACC_W=7 saturation, PIM_LAT=3) share one stimulus.
module tb_pim_psum_collector;
  logic clk, rst, start, in_valid, out_ready;
  int   vectors, miscompares;

  pim_psum_collector_if #(.DEPTH(5), .ADC_P(6), .ACC_W(12)) bus0 ();
  pim_psum_collector_if #(.DEPTH(5), .ADC_P(6), .ACC_W(7))  bus1 ();
  pim_psum_collector_if #(.DEPTH(5), .ADC_P(6), .ACC_W(12)) bus2 ();

  pim_psum_collector #(.DEPTH(5), .ADC_P(6), .ACC_W(12), .NUM_TILES(4), .PIM_LAT(1))
    u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
  pim_psum_collector #(.DEPTH(5), .ADC_P(6), .ACC_W(7), .NUM_TILES(4), .PIM_LAT(1))
    u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
  pim_psum_collector #(.DEPTH(5), .ADC_P(6), .ACC_W(12), .NUM_TILES(4), .PIM_LAT(3))
    u_dut2 (.clk(clk), .rst(rst), .bus(bus2));

  assign bus0.start = start;  assign bus0.in_valid = in_valid;  assign bus0.out_ready = out_ready;
  assign bus1.start = start;  assign bus1.in_valid = in_valid;  assign bus1.out_ready = out_ready;
  assign bus2.start = start;  assign bus2.in_valid = in_valid;  assign bus2.out_ready = out_ready;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Macro models: result = col + tile (latency 1 and 3), constant 63 for the saturation unit.
  int tile0, tile2;
  logic [5:0] m0, m2a, m2b, m2c;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      tile0 <= 0; tile2 <= 0; m0 <= 0; m2a <= 0; m2b <= 0; m2c <= 0;
    end else begin
      if (start && !bus0.busy) tile0 <= 0;
      else if (bus0.in_ready) tile0 <= tile0 + 1;
      if (start && !bus2.busy) tile2 <= 0;
      else if (bus2.in_ready) tile2 <= tile2 + 1;
      m0  <= bus0.pim_en ? 6'(int'(bus0.pim_addr) + tile0) : 6'd0;
      m2a <= bus2.pim_en ? 6'(int'(bus2.pim_addr) + tile2) : 6'd0;
      m2b <= m2a;
      m2c <= m2b;
    end
  end
  assign bus0.pim_out = m0;
  assign bus1.pim_out = 6'd63;
  assign bus2.pim_out = m2c;

  // Observations gathered by drive_job, judged by the scenario tasks.
  int obs_first_ov [3];
  int obs_ir [3][8];
  int obs_ir_n [3];
  int obs_xcol [3][32];
  int obs_xdata [3][32];
  int obs_xlast [3][32];
  int obs_nx [3];
  int obs_extra, obs_busy_end, obs_en_err, obs_hold_err, obs_stall_cyc, obs_pre_addr;
  logic [26:0] obs_abort_vec;

  task automatic record(input int i, input int k, input logic ir, input logic ov,
                        input logic ordy, input int col, input int data, input logic last);
    if (ir && obs_ir_n[i] < 8) begin
      obs_ir[i][obs_ir_n[i]] = k;
      obs_ir_n[i]++;
    end
    if (ov && obs_first_ov[i] < 0) obs_first_ov[i] = k;
    if (ov && ordy && obs_nx[i] < 32) begin
      obs_xcol[i][obs_nx[i]]  = col;
      obs_xdata[i][obs_nx[i]] = data;
      obs_xlast[i][obs_nx[i]] = int'(last);
      obs_nx[i]++;
    end
  endtask

  // Runs one job; cycle 0 is the cycle start is high. abort_at >= 0 asserts rst in that cycle.
  task automatic drive_job(input bit toggle, input bit stall, input bit glitch, input int abort_at);
    int k;
    int stall_left;
    bit stall_arm;
    for (int i = 0; i < 3; i++) begin
      obs_first_ov[i] = -1; obs_ir_n[i] = 0; obs_nx[i] = 0;
    end
    obs_extra = 0; obs_busy_end = 0; obs_en_err = 0; obs_hold_err = 0; obs_stall_cyc = 0;
    stall_left = 0; stall_arm = 0;
    @(posedge clk); #1;
    start = 1'b1; in_valid = 1'b1; out_ready = 1'b1; k = 0;
    while (k < 400) begin
      @(negedge clk);
      record(0, k, bus0.in_ready, bus0.out_valid, out_ready, int'(bus0.out_col),
             int'(bus0.out_data), bus0.out_last);
      record(1, k, bus1.in_ready, bus1.out_valid, out_ready, int'(bus1.out_col),
             int'(bus1.out_data), bus1.out_last);
      record(2, k, bus2.in_ready, bus2.out_valid, out_ready, int'(bus2.out_col),
             int'(bus2.out_data), bus2.out_last);
      if (toggle && k >= 33 && k <= 96 && bus0.pim_en !== in_valid) obs_en_err++;
      if (stall_left > 0) begin
        obs_stall_cyc++;
        if (bus0.out_valid !== 1'b1 || bus0.out_col !== 5'd10 || bus0.out_data !== 12'd46)
          obs_hold_err++;
      end
      if (stall && bus0.out_valid && out_ready && bus0.out_col == 5'd9) stall_arm = 1;
      if (obs_nx[0] == 32 && obs_nx[1] == 32 && obs_nx[2] == 32) break;
      @(posedge clk); #1;
      k++;
      start = glitch && (k == 50 || k == 133);
      if (k == abort_at) begin
        obs_pre_addr = int'(bus0.pim_addr);
        start = 1'b0; in_valid = 1'b0;
        rst = 1'b1;
        #1;
        obs_abort_vec = {bus0.busy, bus0.in_ready, bus0.pim_en, bus0.pim_addr, bus0.out_valid,
                         bus0.out_data, bus0.out_col, bus0.out_last};
        return;
      end
      in_valid = (toggle && k >= 33 && k <= 96) ? (k % 2 == 0) : 1'b1;
      if (stall_left > 0) stall_left--;
      else if (stall_arm) begin
        stall_left = 5;
        stall_arm  = 0;
      end
      out_ready = (stall_left == 0);
    end
    // Trailing cycles: nothing more may be streamed and all units must be idle.
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (bus0.out_valid || bus1.out_valid || bus2.out_valid) obs_extra++;
      @(posedge clk); #1;
    end
    @(negedge clk);
    obs_busy_end = int'(bus0.busy) + int'(bus1.busy) + int'(bus2.busy);
  endtask

  task automatic test_reset;
    @(negedge clk);
    vectors++; if (bus0.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", bus0.busy); end
    vectors++; if (bus0.in_ready !== 1'b0) begin miscompares++; $display("FAIL reset_in_ready got %b want 0", bus0.in_ready); end
    vectors++; if (bus0.pim_en !== 1'b0) begin miscompares++; $display("FAIL reset_pim_en got %b want 0", bus0.pim_en); end
    vectors++; if (bus0.pim_addr !== 5'd0) begin miscompares++; $display("FAIL reset_pim_addr got %0d want 0", bus0.pim_addr); end
    vectors++; if (bus0.out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got %b want 0", bus0.out_valid); end
    vectors++; if (bus0.out_data !== 12'd0) begin miscompares++; $display("FAIL reset_out_data got %0d want 0", bus0.out_data); end
    vectors++; if (bus0.out_col !== 5'd0 || bus0.out_last !== 1'b0) begin miscompares++; $display("FAIL reset_out_col_last got %0d/%b want 0/0", bus0.out_col, bus0.out_last); end
    vectors++; if ({bus1.busy, bus2.busy, bus1.out_valid, bus2.out_valid} !== 4'b0) begin miscompares++; $display("FAIL reset_other_units got %b want 0000", {bus1.busy, bus2.busy, bus1.out_valid, bus2.out_valid}); end
    rst = 1'b0;
  endtask

  task automatic check_sums(input int i, input string tag);
    vectors++; if (obs_nx[i] !== 32) begin miscompares++; $display("FAIL %s_count unit%0d got %0d want 32", tag, i, obs_nx[i]); end
    for (int n = 0; n < obs_nx[i]; n++) begin
      vectors++;
      if (obs_xcol[i][n] !== n || obs_xdata[i][n] !== 4 * n + 6 || obs_xlast[i][n] !== int'(n == 31)) begin
        miscompares++;
        $display("FAIL %s_xfer unit%0d #%0d got col=%0d data=%0d last=%0d want col=%0d data=%0d last=%0d",
                 tag, i, n, obs_xcol[i][n], obs_xdata[i][n], obs_xlast[i][n], n, 4 * n + 6, int'(n == 31));
      end
    end
  endtask

  task automatic test_accumulate;
    int exp_ir [4] = '{32, 64, 96, 128};
    drive_job(0, 0, 0, -1);
    vectors++; if (obs_ir_n[0] !== 4) begin miscompares++; $display("FAIL acc_in_ready_count got %0d want 4", obs_ir_n[0]); end
    for (int j = 0; j < 4 && j < obs_ir_n[0]; j++) begin
      vectors++; if (obs_ir[0][j] !== exp_ir[j]) begin miscompares++; $display("FAIL acc_in_ready_cycle #%0d got %0d want %0d", j, obs_ir[0][j], exp_ir[j]); end
    end
    vectors++; if (obs_first_ov[0] !== 130) begin miscompares++; $display("FAIL acc_first_out_valid got %0d want 130", obs_first_ov[0]); end
    vectors++; if (obs_first_ov[2] !== 132) begin miscompares++; $display("FAIL lat3_first_out_valid got %0d want 132", obs_first_ov[2]); end
    check_sums(0, "acc");
    check_sums(2, "lat3");
    vectors++; if (obs_extra !== 0 || obs_busy_end !== 0) begin miscompares++; $display("FAIL acc_after_drain got extra=%0d busy=%0d want 0/0", obs_extra, obs_busy_end); end
  endtask

  task automatic test_saturate;
    drive_job(0, 0, 0, -1);
    vectors++; if (obs_nx[1] !== 32) begin miscompares++; $display("FAIL sat_count got %0d want 32", obs_nx[1]); end
    for (int n = 0; n < obs_nx[1]; n++) begin
      vectors++; if (obs_xdata[1][n] !== 127 || obs_xcol[1][n] !== n) begin miscompares++; $display("FAIL sat_xfer #%0d got col=%0d data=%0d want col=%0d data=127", n, obs_xcol[1][n], obs_xdata[1][n], n); end
    end
  endtask

  task automatic test_toggle;
    int exp_ir [4] = '{32, 96, 128, 160};
    drive_job(1, 0, 0, -1);
    vectors++; if (obs_ir_n[0] !== 4) begin miscompares++; $display("FAIL tog_in_ready_count got %0d want 4", obs_ir_n[0]); end
    for (int j = 0; j < 4 && j < obs_ir_n[0]; j++) begin
      vectors++; if (obs_ir[0][j] !== exp_ir[j]) begin miscompares++; $display("FAIL tog_in_ready_cycle #%0d got %0d want %0d", j, obs_ir[0][j], exp_ir[j]); end
    end
    vectors++; if (obs_en_err !== 0) begin miscompares++; $display("FAIL tog_pim_en_mirror got %0d mismatching cycles want 0", obs_en_err); end
    vectors++; if (obs_first_ov[0] !== 162) begin miscompares++; $display("FAIL tog_first_out_valid got %0d want 162", obs_first_ov[0]); end
    check_sums(0, "tog");
    check_sums(2, "tog_lat3");
  endtask

  task automatic test_stall;
    drive_job(0, 1, 0, -1);
    vectors++; if (obs_stall_cyc !== 5) begin miscompares++; $display("FAIL stall_cycles got %0d want 5", obs_stall_cyc); end
    vectors++; if (obs_hold_err !== 0) begin miscompares++; $display("FAIL stall_hold got %0d unstable cycles want 0", obs_hold_err); end
    vectors++; if (obs_extra !== 0) begin miscompares++; $display("FAIL stall_extra got %0d want 0", obs_extra); end
    check_sums(0, "stall");
    check_sums(2, "stall_lat3");
  endtask

  task automatic test_reset_abort;
    drive_job(0, 0, 0, 82);
    vectors++; if (obs_pre_addr !== 17) begin miscompares++; $display("FAIL abort_point got addr %0d want 17", obs_pre_addr); end
    vectors++; if (obs_abort_vec !== 27'd0) begin miscompares++; $display("FAIL abort_outputs got %h want 0", obs_abort_vec); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    drive_job(0, 0, 0, -1);
    check_sums(0, "post_abort");
    vectors++; if (obs_first_ov[0] !== 130) begin miscompares++; $display("FAIL post_abort_first_out_valid got %0d want 130", obs_first_ov[0]); end
  endtask

  task automatic test_start_ignored;
    int exp_ir [4] = '{32, 64, 96, 128};
    drive_job(0, 0, 1, -1);
    vectors++; if (obs_ir_n[0] !== 4) begin miscompares++; $display("FAIL glitch_in_ready_count got %0d want 4", obs_ir_n[0]); end
    for (int j = 0; j < 4 && j < obs_ir_n[0]; j++) begin
      vectors++; if (obs_ir[0][j] !== exp_ir[j]) begin miscompares++; $display("FAIL glitch_in_ready_cycle #%0d got %0d want %0d", j, obs_ir[0][j], exp_ir[j]); end
    end
    vectors++; if (obs_first_ov[2] !== 132) begin miscompares++; $display("FAIL glitch_lat3_first_out_valid got %0d want 132", obs_first_ov[2]); end
    check_sums(0, "glitch");
    check_sums(2, "glitch_lat3");
    vectors++; if (obs_extra !== 0 || obs_busy_end !== 0) begin miscompares++; $display("FAIL glitch_after_drain got extra=%0d busy=%0d want 0/0", obs_extra, obs_busy_end); end
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    test_reset;
    test_accumulate;
    test_saturate;
    test_toggle;
    test_stall;
    test_reset_abort;
    test_start_ignored;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
